// File: rtl/tree_path_if.sv
// Insert, lookup and response handshakes shared by the tree path controller and its requesters.
interface tree_path_if #(
  parameter int unsigned IDENTIFIER_SIZE = 8,
  parameter int unsigned NODE_ADDR_SIZE  = 8
);

  logic                       ins_valid;
  logic                       ins_ready;
  logic [IDENTIFIER_SIZE-1:0] ins_id;
  logic                       ins_last;

  logic                       lkp_valid;
  logic                       lkp_ready;
  logic [IDENTIFIER_SIZE-1:0] lkp_id;
  logic                       lkp_last;

  logic                       rsp_valid;
  logic                       rsp_ready;
  logic                       rsp_op;
  logic                       rsp_hit;
  logic                       rsp_new;
  logic                       rsp_err;
  logic [NODE_ADDR_SIZE-1:0]  rsp_addr;

  // Requester side: drives path beats, consumes responses.
  modport master (
    output ins_valid, ins_id, ins_last,
    input  ins_ready,
    output lkp_valid, lkp_id, lkp_last,
    input  lkp_ready,
    input  rsp_valid, rsp_op, rsp_hit, rsp_new, rsp_err, rsp_addr,
    output rsp_ready
  );

  // Controller side.
  modport slave (
    input  ins_valid, ins_id, ins_last,
    output ins_ready,
    input  lkp_valid, lkp_id, lkp_last,
    output lkp_ready,
    output rsp_valid, rsp_op, rsp_hit, rsp_new, rsp_err, rsp_addr,
    input  rsp_ready
  );

endinterface

// File: rtl/tree_path_ctrl.sv
// Message-dependency tree node store shared between an insert and a lookup requester.
// Paths arrive one identifier per beat; child lists are walked one slot per cycle.
module tree_path_ctrl #(
  parameter int unsigned IDENTIFIER_SIZE     = 8,
  parameter int unsigned NODE_ADDR_SIZE      = 8,
  parameter int unsigned MAX_NODES_PER_LEVEL = 4,
  parameter int unsigned NUM_NODES           = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  tree_path_if.slave              bus,
  output logic [NODE_ADDR_SIZE:0] node_count
);

  localparam int unsigned IDX_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int unsigned K_W   = (MAX_NODES_PER_LEVEL > 1) ? $clog2(MAX_NODES_PER_LEVEL) : 1;
  localparam int unsigned CNT_W = NODE_ADDR_SIZE + 1;

  localparam logic [K_W-1:0]   K_LAST  = K_W'(MAX_NODES_PER_LEVEL - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_NODES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BEAT,
    S_SCAN,
    S_ALLOC,
    S_DRAIN,
    S_RESP
  } state_t;

  typedef struct packed {
    logic [IDENTIFIER_SIZE-1:0] id;
    logic [NODE_ADDR_SIZE-1:0]  parent;
  } node_t;

  node_t                     nodes [NUM_NODES];
  logic [NODE_ADDR_SIZE-1:0] child [NUM_NODES][MAX_NODES_PER_LEVEL];

  state_t                     state;
  logic                       grant_lkp;
  logic                       last_lkp;
  logic [NODE_ADDR_SIZE-1:0]  cur;
  logic [K_W-1:0]             k;
  logic [IDENTIFIER_SIZE-1:0] id_q;
  logic                       last_q;
  logic                       new_q;
  logic                       err_q;

  // Beat view of whichever port currently owns the controller.
  logic                       beat_valid;
  logic                       beat_fire;
  logic                       beat_last;
  logic [IDENTIFIER_SIZE-1:0] beat_id;
  logic                       pick_lkp;

  assign beat_valid = grant_lkp ? bus.lkp_valid : bus.ins_valid;
  assign beat_fire  = beat_valid & (grant_lkp ? bus.lkp_ready : bus.ins_ready);
  assign beat_last  = grant_lkp ? bus.lkp_last : bus.ins_last;
  assign beat_id    = grant_lkp ? bus.lkp_id : bus.ins_id;

  // Round-robin only matters when both ports contend; a lone requester always wins.
  assign pick_lkp = bus.lkp_valid & (~bus.ins_valid | ~last_lkp);

  // Slot under inspection during the child-list walk.
  logic [NODE_ADDR_SIZE-1:0] scan_child;
  logic                      scan_match;
  logic                      scan_end;
  logic                      has_room;

  assign scan_child = child[IDX_W'(cur)][k];
  assign scan_match = (scan_child != '0) && (nodes[IDX_W'(scan_child)].id == id_q);
  assign scan_end   = (scan_child == '0) || (k == K_LAST);
  assign has_room   = node_count < CNT_MAX;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      grant_lkp     <= 1'b0;
      last_lkp      <= 1'b1;
      cur           <= '0;
      k             <= '0;
      id_q          <= '0;
      last_q        <= 1'b0;
      new_q         <= 1'b0;
      err_q         <= 1'b0;
      node_count    <= CNT_W'(1);
      bus.ins_ready <= 1'b0;
      bus.lkp_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_op    <= 1'b0;
      bus.rsp_hit   <= 1'b0;
      bus.rsp_new   <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_addr  <= '0;
      for (int n = 0; n < NUM_NODES; n++) begin
        nodes[n] <= '0;
        for (int s = 0; s < MAX_NODES_PER_LEVEL; s++) begin
          child[n][s] <= '0;
        end
      end
    end else begin
      // Ready is only raised on cycles that will be spent in BEAT or DRAIN.
      bus.ins_ready <= 1'b0;
      bus.lkp_ready <= 1'b0;

      unique case (state)
        S_IDLE: begin
          cur   <= '0;
          k     <= '0;
          new_q <= 1'b0;
          err_q <= 1'b0;
          if (bus.ins_valid || bus.lkp_valid) begin
            grant_lkp     <= pick_lkp;
            bus.ins_ready <= ~pick_lkp;
            bus.lkp_ready <= pick_lkp;
            if (bus.ins_valid && bus.lkp_valid) begin
              last_lkp <= pick_lkp;
            end
            state <= S_BEAT;
          end
        end

        S_BEAT: begin
          if (beat_fire && (beat_id != '0)) begin
            id_q   <= beat_id;
            last_q <= beat_last;
            k      <= '0;
            state  <= S_SCAN;
          end else if (beat_fire && beat_last) begin
            // Zero identifiers are skipped; the path ends on the node reached so far.
            bus.rsp_valid <= 1'b1;
            bus.rsp_op    <= grant_lkp;
            bus.rsp_hit   <= 1'b1;
            bus.rsp_new   <= new_q;
            bus.rsp_err   <= 1'b0;
            bus.rsp_addr  <= cur;
            state         <= S_RESP;
          end else begin
            bus.ins_ready <= ~grant_lkp;
            bus.lkp_ready <= grant_lkp;
          end
        end

        S_SCAN: begin
          if (scan_match) begin
            cur <= scan_child;
            if (last_q) begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_op    <= grant_lkp;
              bus.rsp_hit   <= 1'b1;
              bus.rsp_new   <= new_q;
              bus.rsp_err   <= 1'b0;
              bus.rsp_addr  <= scan_child;
              state         <= S_RESP;
            end else begin
              bus.ins_ready <= ~grant_lkp;
              bus.lkp_ready <= grant_lkp;
              state         <= S_BEAT;
            end
          end else if (scan_end) begin
            if (!grant_lkp && (scan_child == '0) && has_room) begin
              state <= S_ALLOC;
            end else begin
              // Lookup miss, full child list or full store: discard the rest of the path.
              err_q <= ~grant_lkp;
              if (last_q) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_op    <= grant_lkp;
                bus.rsp_hit   <= 1'b0;
                bus.rsp_new   <= new_q;
                bus.rsp_err   <= ~grant_lkp;
                bus.rsp_addr  <= '0;
                state         <= S_RESP;
              end else begin
                bus.ins_ready <= ~grant_lkp;
                bus.lkp_ready <= grant_lkp;
                state         <= S_DRAIN;
              end
            end
          end else begin
            k <= k + K_W'(1);
          end
        end

        S_ALLOC: begin
          child[IDX_W'(cur)][k]       <= NODE_ADDR_SIZE'(node_count);
          nodes[IDX_W'(node_count)]   <= '{id: id_q, parent: cur};
          for (int s = 0; s < MAX_NODES_PER_LEVEL; s++) begin
            child[IDX_W'(node_count)][s] <= '0;
          end
          cur        <= NODE_ADDR_SIZE'(node_count);
          node_count <= node_count + CNT_W'(1);
          new_q      <= 1'b1;
          if (last_q) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_op    <= grant_lkp;
            bus.rsp_hit   <= 1'b1;
            bus.rsp_new   <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_addr  <= NODE_ADDR_SIZE'(node_count);
            state         <= S_RESP;
          end else begin
            bus.ins_ready <= ~grant_lkp;
            bus.lkp_ready <= grant_lkp;
            state         <= S_BEAT;
          end
        end

        S_DRAIN: begin
          if (beat_fire && beat_last) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_op    <= grant_lkp;
            bus.rsp_hit   <= 1'b0;
            bus.rsp_new   <= new_q;
            bus.rsp_err   <= err_q;
            bus.rsp_addr  <= '0;
            state         <= S_RESP;
          end else begin
            bus.ins_ready <= ~grant_lkp;
            bus.lkp_ready <= grant_lkp;
          end
        end

        S_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tree_path_ctrl.sv
// Directed bench for tree_path_ctrl: insert/lookup paths, skipped zero beats, slot and store
// exhaustion, port arbitration with response back-pressure, and reset in the middle of a walk.
module tb_tree_path_ctrl;

  logic       clk;
  logic       rst;
  logic [8:0] node_count;

  int n_checks;
  int n_errors;

  tree_path_if #(.IDENTIFIER_SIZE(8), .NODE_ADDR_SIZE(8)) bus ();

  tree_path_ctrl #(
    .IDENTIFIER_SIZE    (8),
    .NODE_ADDR_SIZE     (8),
    .MAX_NODES_PER_LEVEL(4),
    .NUM_NODES          (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .node_count(node_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit lkp, input bit v, input logic [7:0] id, input bit last);
    if (lkp) begin
      bus.lkp_valid = v;
      bus.lkp_id    = id;
      bus.lkp_last  = last;
    end else begin
      bus.ins_valid = v;
      bus.ins_id    = id;
      bus.ins_last  = last;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'd0, 1'b0);
    drive(1'b1, 1'b0, 8'd0, 1'b0);
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Sends n beats (ids a, b, c); starts and ends on a falling edge.
  task automatic send_path(input bit lkp, input int n,
                           input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] ids [3];
    int         w;
    ids[0] = a;
    ids[1] = b;
    ids[2] = c;
    for (int i = 0; i < n; i++) begin
      drive(lkp, 1'b1, ids[i], i == n - 1);
      w = 0;
      while (!(lkp ? bus.lkp_ready : bus.ins_ready)) begin
        @(negedge clk);
        w++;
        if (w > 100) begin
          check("beat_timeout", 32'd0, 32'd1);
          drive(lkp, 1'b0, 8'd0, 1'b0);
          return;
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    drive(lkp, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic expect_rsp(input string tag, input bit op, input bit hit, input bit nw,
                            input bit err, input logic [7:0] addr);
    int w;
    w = 0;
    while (!bus.rsp_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    check({tag, ".valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, ".op"},    32'(bus.rsp_op),    32'(op));
    check({tag, ".hit"},   32'(bus.rsp_hit),   32'(hit));
    check({tag, ".new"},   32'(bus.rsp_new),   32'(nw));
    check({tag, ".err"},   32'(bus.rsp_err),   32'(err));
    check({tag, ".addr"},  32'(bus.rsp_addr),  32'(addr));
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.ins_valid = 1'b0;
    bus.ins_id    = '0;
    bus.ins_last  = 1'b0;
    bus.lkp_valid = 1'b0;
    bus.lkp_id    = '0;
    bus.lkp_last  = 1'b0;
    bus.rsp_ready = 1'b0;

    do_reset();
    check("rst.rsp_valid",  32'(bus.rsp_valid), 32'd0);
    check("rst.ins_ready",  32'(bus.ins_ready), 32'd0);
    check("rst.lkp_ready",  32'(bus.lkp_ready), 32'd0);
    check("rst.rsp_addr",   32'(bus.rsp_addr),  32'd0);
    check("rst.node_count", 32'(node_count),    32'd1);

    // Basic insert / lookup / re-insert.
    send_path(1'b0, 2, 8'd5, 8'd7, 8'd0);
    expect_rsp("ins57", 1'b0, 1'b1, 1'b1, 1'b0, 8'd2);
    check("ins57.count", 32'(node_count), 32'd3);

    send_path(1'b1, 2, 8'd5, 8'd7, 8'd0);
    expect_rsp("lkp57", 1'b1, 1'b1, 1'b0, 1'b0, 8'd2);

    send_path(1'b1, 3, 8'd5, 8'd9, 8'd3);
    expect_rsp("lkp593", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    check("lkp593.count", 32'(node_count), 32'd3);

    send_path(1'b1, 1, 8'd0, 8'd0, 8'd0);
    expect_rsp("lkp0", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);

    send_path(1'b0, 2, 8'd5, 8'd7, 8'd0);
    expect_rsp("reins57", 1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
    check("reins57.count", 32'(node_count), 32'd3);

    send_path(1'b0, 3, 8'd5, 8'd0, 8'd8);
    expect_rsp("ins508", 1'b0, 1'b1, 1'b1, 1'b0, 8'd3);
    check("ins508.count", 32'(node_count), 32'd4);

    // Child-slot exhaustion at the root, then store exhaustion.
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      send_path(1'b0, 1, 8'(i), 8'd0, 8'd0);
      expect_rsp("root_child", 1'b0, 1'b1, 1'b1, 1'b0, 8'(i));
    end
    send_path(1'b0, 1, 8'd6, 8'd0, 8'd0);
    expect_rsp("slot_full", 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    check("slot_full.count", 32'(node_count), 32'd5);

    for (int i = 0; i < 3; i++) begin
      send_path(1'b0, 2, 8'd1, 8'(10 + i), 8'd0);
      expect_rsp("fill", 1'b0, 1'b1, 1'b1, 1'b0, 8'(5 + i));
    end
    check("fill.count", 32'(node_count), 32'd8);
    send_path(1'b0, 2, 8'd2, 8'd13, 8'd0);
    expect_rsp("store_full", 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    check("store_full.count", 32'(node_count), 32'd8);

    // Both ports valid together; insert wins first, response back-pressured.
    do_reset();
    drive(1'b0, 1'b1, 8'd5, 1'b1);
    drive(1'b1, 1'b1, 8'd5, 1'b1);
    @(negedge clk);
    check("arb.ins_ready", 32'(bus.ins_ready), 32'd1);
    check("arb.lkp_ready", 32'(bus.lkp_ready), 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'd0, 1'b0);
    check("arb.scan_ins_ready", 32'(bus.ins_ready), 32'd0);
    w = 0;
    while (!bus.rsp_valid && w < 50) begin
      check("arb.wait_lkp_ready", 32'(bus.lkp_ready), 32'd0);
      @(negedge clk);
      w++;
    end
    for (int i = 0; i < 5; i++) begin
      check("hold.valid",     32'(bus.rsp_valid), 32'd1);
      check("hold.op",        32'(bus.rsp_op),    32'd0);
      check("hold.addr",      32'(bus.rsp_addr),  32'd1);
      check("hold.new",       32'(bus.rsp_new),   32'd1);
      check("hold.lkp_ready", 32'(bus.lkp_ready), 32'd0);
      @(negedge clk);
    end
    expect_rsp("arb.ins", 1'b0, 1'b1, 1'b1, 1'b0, 8'd1);
    w = 0;
    while (!bus.lkp_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("arb.lkp_granted", 32'(bus.lkp_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 1'b0, 8'd0, 1'b0);
    expect_rsp("arb.lkp", 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);

    // Reset while an insert is walking the root's child list.
    do_reset();
    drive(1'b0, 1'b1, 8'd5, 1'b1);
    w = 0;
    while (!bus.ins_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst.rsp_valid",  32'(bus.rsp_valid), 32'd0);
    check("midrst.ins_ready",  32'(bus.ins_ready), 32'd0);
    check("midrst.node_count", 32'(node_count),    32'd1);
    drive(1'b0, 1'b0, 8'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_path(1'b1, 1, 8'd5, 8'd0, 8'd0);
    expect_rsp("midrst.lkp5", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    check("midrst.count", 32'(node_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
